// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Purpose  : PS/2 host-to-device transmitter (open-drain clock/data) with watchdog
// Revision : 1.0
// ============================================================================
module ps2_tx #(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2d,
   inout  wire        ps2c,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       ack_err,
   output logic       timeout
);

   localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      filt_q, filt_d;
   logic            fval_q, fval_d;
   logic            fall_tick;
   logic [8:0]      sh_q, sh_d;
   logic [3:0]      n_q, n_d;
   logic            bit_q, bit_d;
   logic            ack_q, ack_d;
   logic [IW-1:0]   inh_q, inh_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic            c_oe, d_oe, wd_hit;

   always_comb begin
      filt_d = {ps2c, filt_q[7:1]};
      fval_d = fval_q;
      if (filt_q == 8'hFF)
         fval_d = 1'b1;
      else if (filt_q == 8'h00)
         fval_d = 1'b0;
   end

   assign fall_tick = fval_q & ~fval_d;
   assign tx_idle   = (state_q == IDLE);
   assign wd_hit    = (state_q != IDLE) && (state_q != RTS) && (wd_q == WW'(TIMEOUT_CYC));

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      n_d          = n_q;
      bit_d        = bit_q;
      ack_d        = ack_q;
      inh_d        = inh_q;
      wd_d         = wd_q;
      c_oe         = 1'b0;
      d_oe         = 1'b0;
      tx_done_tick = 1'b0;
      ack_err      = 1'b0;
      timeout      = 1'b0;
      if ((state_q != IDLE) && (state_q != RTS))
         wd_d = wd_q + WW'(1);
      case (state_q)
         IDLE: begin
            if (wr_ps2) begin
               sh_d    = {~^din, din};
               inh_d   = IW'(INHIBIT_CYC - 1);
               state_d = RTS;
            end
         end
         RTS: begin
            c_oe = 1'b1;
            d_oe = (inh_q == '0);
            if (inh_q == '0) begin
               wd_d    = '0;
               state_d = START;
            end else begin
               inh_d = inh_q - IW'(1);
            end
         end
         START: begin
            d_oe = 1'b1;
            if (fall_tick) begin
               bit_d   = sh_q[0];
               sh_d    = {1'b0, sh_q[8:1]};
               n_d     = 4'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            d_oe = ~bit_q;
            if (fall_tick) begin
               // n_q==8 means parity is on the wire; this edge ends it and releases for stop
               if (n_q == 4'd8) begin
                  state_d = STOP;
               end else begin
                  bit_d = sh_q[0];
                  sh_d  = {1'b0, sh_q[8:1]};
                  n_d   = n_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (fall_tick) begin
               ack_d   = ps2d;
               state_d = ACK;
            end
         end
         ACK: begin
            if (fval_q)
               state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (fval_q && (ps2d == 1'b1)) begin
               tx_done_tick = 1'b1;
               ack_err      = ack_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Watchdog overrides everything, including a completion in the same cycle
      if (wd_hit) begin
         c_oe         = 1'b0;
         d_oe         = 1'b0;
         tx_done_tick = 1'b1;
         ack_err      = 1'b1;
         timeout      = 1'b1;
         state_d      = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         filt_q  <= 8'hFF;
         fval_q  <= 1'b1;
         sh_q    <= '0;
         n_q     <= '0;
         bit_q   <= 1'b1;
         ack_q   <= 1'b0;
         inh_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         fval_q  <= fval_d;
         sh_q    <= sh_d;
         n_q     <= n_d;
         bit_q   <= bit_d;
         ack_q   <= ack_d;
         inh_q   <= inh_d;
         wd_q    <= wd_d;
      end
   end

   assign ps2c = c_oe ? 1'b0 : 1'bz;
   assign ps2d = d_oe ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Purpose  : Self-checking bench for ps2_tx with a PS/2 device model and scoreboard
// Revision : 1.0
// ============================================================================
module tb_ps2_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle, tx_done_tick, ack_err, timeout;
   logic       dev_c_low, dev_d_low;
   wire        ps2c, ps2d;

   pullup pu_c (ps2c);
   pullup pu_d (ps2d);
   assign ps2c = dev_c_low ? 1'b0 : 1'bz;
   assign ps2d = dev_d_low ? 1'b0 : 1'bz;

   ps2_tx #(.INHIBIT_CYC(5000), .TIMEOUT_CYC(2000)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_ps2       (wr_ps2),
      .din          (din),
      .ps2d         (ps2d),
      .ps2c         (ps2c),
      .tx_idle      (tx_idle),
      .tx_done_tick (tx_done_tick),
      .ack_err      (ack_err),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic       exp_par;
      bit         dev_ack;
      bit         dev_clocks;
      bit         inject;
      bit         do_reset;
      bit         wr_on_done;
      logic       exp_ack_err;
      logic       exp_timeout;
   } vec_t;

   typedef struct {
      logic [7:0] din;
      logic       par;
      logic       ack_err;
      logic       timeout;
      bit         has_bits;
   } exp_t;

   exp_t       sb[$];
   exp_t       sb_e;
   vec_t       vecs[7];
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       prev_done = 1'b0;
   logic [9:0] cap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every completed frame is matched against the oldest expectation
   always @(negedge clk) begin
      if (tx_done_tick) begin
         done_cnt++;
         done_cyc = cyc;
         chk("done_pulse_width", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            sb_e = sb.pop_front();
            chk("ack_err", 32'(ack_err), 32'(sb_e.ack_err));
            chk("timeout", 32'(timeout), 32'(sb_e.timeout));
            if (sb_e.has_bits) begin
               chk("data_bits", 32'(cap[7:0]), 32'(sb_e.din));
               chk("parity_bit", 32'(cap[8]), 32'(sb_e.par));
               chk("stop_bit", 32'(cap[9]), 32'd1);
            end else begin
               chk("to_ps2c_released", 32'(ps2c), 32'd1);
               chk("to_ps2d_released", 32'(ps2d), 32'd1);
            end
         end
      end
      prev_done = tx_done_tick;
   end

   task automatic run_frame(input vec_t v);
      exp_t e;
      int   low_c, dlow, t0, k, base;
      chk("idle_before_wr", 32'(tx_idle), 32'd1);
      din    = v.din;
      wr_ps2 = 1'b1;
      tick(1);
      wr_ps2 = 1'b0;
      din    = ~v.din;
      chk("idle_drop", 32'(tx_idle), 32'd0);
      if (!v.do_reset) begin
         e.din = v.din;  e.par = v.exp_par;
         e.ack_err = v.exp_ack_err;  e.timeout = v.exp_timeout;
         e.has_bits = v.dev_clocks;
         sb.push_back(e);
      end
      base  = done_cnt;
      low_c = 0;
      dlow  = 0;
      while (ps2c === 1'b0 && low_c < 6000) begin
         low_c++;
         if (ps2d === 1'b0) dlow++;
         tick(1);
      end
      chk("rts_low_cycles", 32'(low_c), 32'd5000);
      chk("rts_data_low_cycles", 32'(dlow), 32'd1);
      chk("start_bit", 32'(ps2d), 32'd0);
      t0 = cyc;
      if (!v.dev_clocks) begin
         k = 0;
         while (done_cnt == base && k < 3000) begin tick(1); k++; end
         chk("timeout_done_seen", 32'(done_cnt - base), 32'd1);
         chk("timeout_latency", 32'(done_cyc - t0), 32'd2000);
         return;
      end
      tick(20);
      for (int i = 0; i < 11; i++) begin
         if (i == 10 && v.dev_ack) dev_d_low = 1'b1;
         dev_c_low = 1'b1;
         tick(20);
         dev_c_low = 1'b0;
         tick(20);
         if (i < 10) cap[i] = ps2d;
         if (v.inject && i == 4) begin
            din    = 8'h00;
            wr_ps2 = 1'b1;
            tick(1);
            wr_ps2 = 1'b0;
            chk("busy_wr_ignored", 32'(tx_idle), 32'd0);
         end
         if (v.do_reset && i == 4) begin
            reset = 1'b1;
            #1;
            chk("rst_ps2d_released", 32'(ps2d), 32'd1);
            chk("rst_ps2c_released", 32'(ps2c), 32'd1);
            chk("rst_tx_idle", 32'(tx_idle), 32'd1);
            chk("rst_no_done", 32'(tx_done_tick), 32'd0);
            tick(2);
            reset = 1'b0;
            tick(30);
            chk("no_done_after_reset", 32'(done_cnt - base), 32'd0);
            return;
         end
      end
      if (v.dev_ack) begin
         if (v.wr_on_done) begin
            din    = 8'h3C;
            wr_ps2 = 1'b1;
         end
         dev_d_low = 1'b0;
         #1;
         chk("done_on_release", 32'(tx_done_tick), 32'd1);
         if (v.wr_on_done) begin
            tick(1);
            wr_ps2 = 1'b0;
            chk("wr_on_done_ignored", 32'(tx_idle), 32'd1);
            tick(3);
            chk("still_idle", 32'(tx_idle), 32'd1);
         end
      end
      k = 0;
      while (done_cnt == base && k < 200) begin tick(1); k++; end
      chk("done_seen", 32'(done_cnt - base), 32'd1);
   endtask

   initial begin
      //          din    par  ack clk inj rst wod  aerr  tout
      vecs[0] = '{8'hFF, 1'b1, 1, 1, 0, 0, 0, 1'b0, 1'b0};
      vecs[1] = '{8'hF4, 1'b0, 1, 1, 0, 0, 0, 1'b0, 1'b0};
      vecs[2] = '{8'hED, 1'b1, 0, 1, 0, 0, 0, 1'b1, 1'b0};
      vecs[3] = '{8'hAA, 1'b1, 1, 1, 1, 0, 0, 1'b0, 1'b0};
      vecs[4] = '{8'h0F, 1'b1, 1, 1, 0, 1, 0, 1'b0, 1'b0};
      vecs[5] = '{8'h55, 1'b1, 1, 1, 0, 0, 1, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 1'b1, 0, 0, 0, 0, 0, 1'b1, 1'b1};

      reset     = 1'b1;
      wr_ps2    = 1'b0;
      din       = 8'h00;
      dev_c_low = 1'b0;
      dev_d_low = 1'b0;
      cap       = '0;
      tick(3);
      chk("reset_tx_idle", 32'(tx_idle), 32'd1);
      chk("reset_done", 32'(tx_done_tick), 32'd0);
      chk("reset_ack_err", 32'(ack_err), 32'd0);
      chk("reset_timeout", 32'(timeout), 32'd0);
      chk("reset_ps2c", 32'(ps2c), 32'd1);
      chk("reset_ps2d", 32'(ps2d), 32'd1);
      reset = 1'b0;
      tick(12);

      for (int v = 0; v < 7; v++) begin
         run_frame(vecs[v]);
         tick(10);
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL global_timeout: got no completion, expected end of test");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000, clock-low hold time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, max cycles per frame before abort (20 ms at 50 MHz).
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port wr_ps2  input  1  write strobe; starts a frame when tx_idle=1.
REQ-006 Port din  input  8  command byte, sampled on the accepted wr_ps2 cycle.
REQ-007 Port ps2d  inout  1  PS/2 data, open-drain (drive 0 or Z only).
REQ-008 Port ps2c  inout  1  PS/2 clock, open-drain (drive 0 or Z only).
REQ-009 Port tx_idle  output  1  high when idle; the team's receiver is gated with it.
REQ-010 Port tx_done_tick  output  1  one-cycle pulse at frame end (success, ack error or timeout).
REQ-011 Port ack_err  output  1  valid with tx_done_tick; 1 = no device ack.
REQ-012 Port timeout  output  1  valid with tx_done_tick; 1 = frame aborted by watchdog.

Function
REQ-013 ps2c input SHALL pass an 8-sample shift filter; the filtered level goes 0 only when all 8 samples are 0 and 1 only when all 8 are 1; fall_tick is one cycle on filtered 1->0.
REQ-014 FSM states SHALL be IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL.
REQ-015 IDLE: both lines released; wr_ps2=1 loads shift register {odd parity (~^din), din} and a clock counter, goes to RTS.
REQ-016 RTS: drive ps2c low for exactly INHIBIT_CYC cycles, with ps2d low during the last cycle; then go to START.
REQ-017 START: ps2c released, ps2d driven low (start bit); on fall_tick present din[0] and go to DATA.
REQ-018 DATA: on each fall_tick shift the next bit onto ps2d (d1..d7, then parity); ps2d driven low for bit 0, released for bit 1; after the fall_tick that follows parity, release ps2d (stop) and go to STOP.
REQ-019 STOP: on next fall_tick sample the raw ps2d: 0 = ack ok, 1 = ack_err; go to ACK.
REQ-020 ACK/WAIT_REL: wait until filtered ps2c=1 and raw ps2d=1, then pulse tx_done_tick with ack_err/timeout valid, and return to IDLE.
REQ-021 Total falling edges consumed per frame SHALL be 11: data/parity transitions 8+1, stop 1, ack 1.
REQ-022 Watchdog SHALL count from entry to START; reaching TIMEOUT_CYC in any state except IDLE/RTS releases both lines, pulses tx_done_tick with timeout=1 and ack_err=1, and returns to IDLE.
REQ-023 wr_ps2 while tx_idle=0 SHALL be ignored; din changes after acceptance SHALL NOT affect the frame.
REQ-024 tx_idle SHALL be 1 only in IDLE; it drops the cycle after an accepted wr_ps2.
REQ-025 ps2c SHALL never be driven outside RTS; ps2d SHALL never be driven in IDLE, STOP, ACK or WAIT_REL.
REQ-026 wr_ps2 asserted in the same cycle as tx_done_tick SHALL be ignored; it is accepted only from the next cycle in IDLE.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) release ps2c and ps2d, set state IDLE, tx_idle=1, tx_done_tick=0, ack_err=0, timeout=0, clear counters, filter to all-1s.
REQ-028 Reset mid-frame SHALL abort without a tx_done_tick; the next wr_ps2 after release starts a fresh frame.

Verification
REQ-029 din=0xFF, device model acks -> ps2c low 5000 cycles, bits 1,1,1,1,1,1,1,1, parity 1, stop 1; tx_done_tick=1, ack_err=0, timeout=0.
REQ-030 din=0xF4 -> bits LSB first 0,0,1,0,1,1,1,1, parity 0; device ack -> ack_err=0.
REQ-031 din=0xED, device leaves ps2d high at 11th fall -> tx_done_tick with ack_err=1, timeout=0.
REQ-032 device never clocks after RTS, TIMEOUT_CYC=2000 -> lines released, tx_done_tick with timeout=1 exactly 2000 cycles after START entry.
REQ-033 second wr_ps2 (din=0x00) during DATA of a 0xAA frame -> ignored; bits on wire match 0xAA only.
REQ-034 reset pulse during DATA bit 4 -> both lines Z same cycle, tx_idle=1, no tx_done_tick; next write of 0x55 completes normally.
